// File: rtl/fft_out_reorder.sv
// fft_out_reorder: natural-order reorder buffer behind a radix-2 MDC FFT.
//
// The FFT delivers each frame as N/2 pairs in bit-reversed order. Pair c carries
// X[bitrev(c)] on the upper stream and X[N/2 + bitrev(c)] on the lower stream. This
// block writes each pair into a two-page ping-pong RAM at bitrev(c). It then reads a
// full page linearly, so each frame comes out as pairs {X[k], X[k+N/2]}, k = 0..N/2-1.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid, in_sof    input pair strobe; first pair of a frame (qualified by in_valid)
//   in_up_re/im         upper FFT output
//   in_dn_re/im         lower FFT output
//   out_valid, out_sof  output pair strobe; high with out_valid on k = 0
//   out_idx             bin index k
//   out_lo_re/im        X[k]
//   out_hi_re/im        X[k+N/2]
//   frame_err           (FFT_OUT_REORDER_ERR_EN only) one-cycle pulse when a frame is
//                       aborted by an early in_sof, or dropped because its page is full
//
// Optional feature macro: FFT_OUT_REORDER_ERR_EN.
module fft_out_reorder #(
    parameter int unsigned DW    = 9,
    parameter int unsigned LOG2N = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic signed [DW-1:0]    in_up_re,
    input  logic signed [DW-1:0]    in_up_im,
    input  logic signed [DW-1:0]    in_dn_re,
    input  logic signed [DW-1:0]    in_dn_im,
`ifdef FFT_OUT_REORDER_ERR_EN
    output logic                    frame_err,
`endif
    output logic                    out_valid,
    output logic                    out_sof,
    output logic [LOG2N-2:0]        out_idx,
    output logic signed [DW-1:0]    out_lo_re,
    output logic signed [DW-1:0]    out_lo_im,
    output logic signed [DW-1:0]    out_hi_re,
    output logic signed [DW-1:0]    out_hi_im
);

    localparam int unsigned AW   = LOG2N - 1;
    localparam int unsigned HALF = 1 << AW;
    localparam int unsigned SW   = 2 * DW;

    typedef enum logic {StIdle, StRead} state_e;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < int'(AW); i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // Banks are addressed {page, bin}; LO holds X[0..N/2-1], HI holds X[N/2..N-1].
    logic [SW-1:0] lo_mem [0:2*HALF-1];
    logic [SW-1:0] hi_mem [0:2*HALF-1];

    // Write side
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_page_q, wr_page_d;
    logic          open_q, open_d;
    logic [1:0]    full_q, full_d;

    // Read side
    state_e        state_q, state_d;
    logic          rd_page_q, rd_page_d;
    logic [AW-1:0] rd_k_q, rd_k_d;

    logic          rd_done;
    logic          page_free;
    logic          sof_acc;
    logic          drop;
    logic          wr_en;
    logic          wr_last;
    logic [AW-1:0] cur_c;
    logic [AW:0]   wr_addr;
    logic [AW:0]   rd_addr;

    assign rd_done = (state_q == StRead) && (rd_k_q == AW'(HALF - 1));
    // A page whose last bin is being read this cycle is free for a write at the same edge:
    // the read is combinational, and the first write lands at bin 0, not at the bin being read.
    assign page_free = !full_q[wr_page_q] || (rd_done && (rd_page_q == wr_page_q));
    assign sof_acc   = in_valid && in_sof;
    assign drop      = sof_acc && !page_free;
    assign cur_c     = in_sof ? '0 : wr_cnt_q;
    assign wr_en     = (sof_acc && page_free) || (in_valid && !in_sof && open_q);
    assign wr_last   = wr_en && (cur_c == AW'(HALF - 1));
    assign wr_addr   = {wr_page_q, bitrev(cur_c)};
    assign rd_addr   = {rd_page_q, rd_k_q};

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_page_d = wr_page_q;
        open_d    = open_q;
        full_d    = full_q;
        if (rd_done) begin
            full_d[rd_page_q] = 1'b0;
        end
        if (drop) begin
            open_d = 1'b0;
        end else if (wr_en) begin
            if (wr_last) begin
                full_d[wr_page_q] = 1'b1;
                wr_page_d         = !wr_page_q;
                open_d            = 1'b0;
                wr_cnt_d          = '0;
            end else begin
                open_d   = 1'b1;
                wr_cnt_d = cur_c + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_page_d = rd_page_q;
        rd_k_d    = rd_k_q;
        case (state_q)
            StIdle: begin
                if (full_q[rd_page_q]) begin
                    state_d = StRead;
                    rd_k_d  = '0;
                end
            end
            StRead: begin
                if (rd_done) begin
                    rd_page_d = !rd_page_q;
                    rd_k_d    = '0;
                    // Chain straight into the other page when it is already waiting.
                    state_d   = full_q[!rd_page_q] ? StRead : StIdle;
                end else begin
                    rd_k_d = rd_k_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            wr_page_q <= 1'b0;
            open_q    <= 1'b0;
            full_q    <= 2'b00;
            state_q   <= StIdle;
            rd_page_q <= 1'b0;
            rd_k_q    <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_page_q <= wr_page_d;
            open_q    <= open_d;
            full_q    <= full_d;
            state_q   <= state_d;
            rd_page_q <= rd_page_d;
            rd_k_q    <= rd_k_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            lo_mem[wr_addr] <= {in_up_re, in_up_im};
            hi_mem[wr_addr] <= {in_dn_re, in_dn_im};
        end
    end

    // Output register; data and index hold while out_valid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_idx   <= '0;
            out_lo_re <= '0;
            out_lo_im <= '0;
            out_hi_re <= '0;
            out_hi_im <= '0;
        end else if (state_q == StRead) begin
            out_valid              <= 1'b1;
            out_sof                <= (rd_k_q == '0);
            out_idx                <= rd_k_q;
            {out_lo_re, out_lo_im} <= lo_mem[rd_addr];
            {out_hi_re, out_hi_im} <= hi_mem[rd_addr];
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end
    end

`ifdef FFT_OUT_REORDER_ERR_EN
    // An open frame always has c != 0, so an accepted sof while open is an abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= (sof_acc && open_q) || drop;
        end
    end
`endif

endmodule
